// File: rtl/spi_cmd_controller_pkg.sv
// Shared constants, state encoding and helpers for the SPI command controller.
// Contents: frame field widths, command/response codes, FSM state type,
// decoded-command kind type and an 8-bit saturating adder.
package spi_cmd_controller_pkg;

    localparam int BRIGHTNESS_WIDTH   = 8;
    localparam int CMD_BITS           = 8;
    localparam int ADDR_BITS          = 8;
    localparam int PAYLOAD_BITS       = 8;
    localparam int MASTER_FRAME_WIDTH = 24;

    localparam logic [CMD_BITS-1:0] CMD_NOP     = 8'h00;
    localparam logic [CMD_BITS-1:0] CMD_LED_SET = 8'h01;
    localparam logic [CMD_BITS-1:0] CMD_LED_GET = 8'h02;
    localparam logic [CMD_BITS-1:0] CMD_STATUS  = 8'h03;
    localparam logic [7:0]          RSP_OK      = 8'h01;
    localparam logic [7:0]          RSP_ERR     = 8'hEE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_RESP
    } state_t;

    typedef enum logic [2:0] {
        KIND_NOP,
        KIND_SET,
        KIND_GET,
        KIND_STATUS,
        KIND_ERR
    } kind_t;

    // Overrun and an EXEC error can land in the same cycle, so the
    // increment is up to 2.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/spi_cmd_controller_if.sv
// Handshake/bus bundle between the spi_slave receive/transmit datapath and
// the command controller.
//   rx_dv, i_cmd, i_addr, i_payload : received frame (slave -> controller)
//   o_slv_frame, o_slv_tx_enb       : response frame (controller -> slave)
// modport master: the spi_slave side; modport slave: the controller.
interface spi_cmd_controller_if;
    import spi_cmd_controller_pkg::*;

    logic                          rx_dv;
    logic [CMD_BITS-1:0]           i_cmd;
    logic [ADDR_BITS-1:0]          i_addr;
    logic [PAYLOAD_BITS-1:0]       i_payload;
    logic [MASTER_FRAME_WIDTH-1:0] o_slv_frame;
    logic                          o_slv_tx_enb;

    modport master (
        output rx_dv, i_cmd, i_addr, i_payload,
        input  o_slv_frame, o_slv_tx_enb
    );

    modport slave (
        input  rx_dv, i_cmd, i_addr, i_payload,
        output o_slv_frame, o_slv_tx_enb
    );

endinterface

// File: rtl/spi_cmd_controller_led_brightness_regfile.sv
// led_brightness_regfile: NUM_LEDS x BRIGHTNESS_WIDTH brightness registers.
//   sysclk, rst          : clock, async active-high reset (all registers to 0)
//   wr_en/wr_addr/wr_data: single write port
//   rd_addr/rd_data      : single combinational read port (0 when out of range)
//   brightness           : flat bus, LED n at [n*BRIGHTNESS_WIDTH +: BRIGHTNESS_WIDTH]
module led_brightness_regfile
    import spi_cmd_controller_pkg::*;
#(
    parameter int NUM_LEDS = 4
) (
    input  logic                                 sysclk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [ADDR_BITS-1:0]                 wr_addr,
    input  logic [BRIGHTNESS_WIDTH-1:0]          wr_data,
    input  logic [ADDR_BITS-1:0]                 rd_addr,
    output logic [BRIGHTNESS_WIDTH-1:0]          rd_data,
    output logic [NUM_LEDS*BRIGHTNESS_WIDTH-1:0] brightness
);

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            brightness <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (wr_addr == ADDR_BITS'(i))
                    brightness[i*BRIGHTNESS_WIDTH +: BRIGHTNESS_WIDTH] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (rd_addr == ADDR_BITS'(i))
                rd_data = brightness[i*BRIGHTNESS_WIDTH +: BRIGHTNESS_WIDTH];
        end
    end

endmodule

// File: rtl/spi_cmd_controller.sv
// spi_cmd_controller: validates frames from spi_slave, executes LED set/get
// and status commands against the brightness register file, and stages the
// response frame for the next SPI transaction.
//   sysclk, rst        : clock, async active-high reset
//   bus (slave)        : received frame in, response frame/valid out
//   o_led_brightness   : flat brightness bus from the register file
//   o_led_update       : one-cycle pulse on any brightness write
//   o_err_cnt          : saturating count of rejected commands and overruns
//   o_busy             : high while a frame is being processed
//
// state  | meaning
// IDLE   | waiting for an rx_dv rising edge
// DECODE | classify latched command, register verdict
// EXEC   | perform register write or count the error
// RESP   | build response frame, raise o_slv_tx_enb
module spi_cmd_controller
    import spi_cmd_controller_pkg::*;
#(
    parameter int NUM_LEDS       = 4,
    parameter int MAX_BRIGHTNESS = 100
) (
    input  logic                                 sysclk,
    input  logic                                 rst,
    spi_cmd_controller_if.slave                  bus,
    output logic [NUM_LEDS*BRIGHTNESS_WIDTH-1:0] o_led_brightness,
    output logic                                 o_led_update,
    output logic [7:0]                           o_err_cnt,
    output logic                                 o_busy
);

    state_t                      state;
    kind_t                       kind;
    logic                        rx_dv_q;
    logic [CMD_BITS-1:0]         cmd_q;
    logic [ADDR_BITS-1:0]        addr_q;
    logic [PAYLOAD_BITS-1:0]     payload_q;
    logic [7:0]                  frame_cnt;
    logic [BRIGHTNESS_WIDTH-1:0] rd_data;
    logic                        rx_rise;
    logic                        overrun;
    logic                        exec_err;
    logic                        wr_en;
    logic [1:0]                  err_inc;

    assign rx_rise  = bus.rx_dv & ~rx_dv_q;
    assign overrun  = rx_rise && (state != ST_IDLE);
    assign exec_err = (state == ST_EXEC) && (kind == KIND_ERR);
    assign wr_en    = (state == ST_EXEC) && (kind == KIND_SET);
    assign err_inc  = {1'b0, overrun} + {1'b0, exec_err};

    led_brightness_regfile #(
        .NUM_LEDS(NUM_LEDS)
    ) u_regfile (
        .sysclk    (sysclk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (addr_q),
        .wr_data   (payload_q[BRIGHTNESS_WIDTH-1:0]),
        .rd_addr   (addr_q),
        .rd_data   (rd_data),
        .brightness(o_led_brightness)
    );

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            kind             <= KIND_NOP;
            rx_dv_q          <= 1'b0;
            cmd_q            <= '0;
            addr_q           <= '0;
            payload_q        <= '0;
            frame_cnt        <= '0;
            o_err_cnt        <= '0;
            o_led_update     <= 1'b0;
            o_busy           <= 1'b0;
            bus.o_slv_frame  <= '0;
            bus.o_slv_tx_enb <= 1'b0;
        end else begin
            rx_dv_q      <= bus.rx_dv;
            o_led_update <= 1'b0;
            o_err_cnt    <= sat_add8(o_err_cnt, err_inc);
            case (state)
                ST_IDLE: begin
                    if (rx_rise) begin
                        cmd_q            <= bus.i_cmd;
                        addr_q           <= bus.i_addr;
                        payload_q        <= bus.i_payload;
                        frame_cnt        <= frame_cnt + 8'd1;
                        bus.o_slv_tx_enb <= 1'b0;
                        o_busy           <= 1'b1;
                        state            <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (cmd_q)
                        CMD_LED_SET:
                            kind <= (addr_q < ADDR_BITS'(NUM_LEDS) &&
                                     payload_q <= PAYLOAD_BITS'(MAX_BRIGHTNESS))
                                    ? KIND_SET : KIND_ERR;
                        CMD_LED_GET:
                            kind <= (addr_q < ADDR_BITS'(NUM_LEDS)) ? KIND_GET : KIND_ERR;
                        CMD_STATUS: kind <= KIND_STATUS;
                        CMD_NOP:    kind <= KIND_NOP;
                        default:    kind <= KIND_ERR;
                    endcase
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    o_led_update <= wr_en;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    case (kind)
                        KIND_SET:    bus.o_slv_frame <= {RSP_OK, addr_q, payload_q};
                        KIND_GET:    bus.o_slv_frame <= {RSP_OK, addr_q, PAYLOAD_BITS'(rd_data)};
                        KIND_STATUS: bus.o_slv_frame <= {RSP_OK, o_err_cnt, frame_cnt};
                        KIND_NOP:    bus.o_slv_frame <= {RSP_OK, 8'h00, 8'h00};
                        default:     bus.o_slv_frame <= {RSP_ERR, addr_q, cmd_q};
                    endcase
                    bus.o_slv_tx_enb <= 1'b1;
                    o_busy           <= 1'b0;
                    state            <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
